counter_scheduler: RTL and testbench
====================================

// Module: counter_scheduler
// PURPOSE
//   Time-shares a single CW-bit up-counter between NREQ requesters, arbitrated round-robin.
//   Each requester asks for an interval of len+1 counting cycles. On completion it receives a one-cycle done pulse.
//   Sits between the user-facing request logic and the shared counter datapath, which is held inside this block.
//   Sequences one interval at a time.
// PARAMETERS
//   NREQ  4  number of requesters (>=2)
//   CW    8  counter / interval length width in bits
// PORTS
//   clk    in   1        clock; all state changes on posedge
//   rst    in   1        asynchronous, active-high reset
//   ena    in   1        count enable; 0 freezes the counter in RUN
//   req    in   NREQ     per-requester request level; held high until done or abort
//   len    in   NREQ*CW  per-requester interval; len[i*CW +: CW]
//   grant  out  NREQ     one-hot owner of the counter; high only in RUN
//   busy   out  1        high in RUN or DONE
//   count  out  CW       current counter value
//   done   out  NREQ     one-cycle completion pulse to the owner
// BEHAVIOUR
//   Reset (async, any time, incl. mid-interval): all outputs 0; state=IDLE; count=0; rr pointer=0.
//   State IDLE:
//     - If any req is high: pick the first requester at or after the rr pointer, searching upward with wrap.
//     - Latch its len and set the one-hot grant; count=0; go to RUN.
//     - Grant is registered: it appears on the edge after req is seen.
//   State RUN:
//     - If req[owner] is low: abort. grant=0, count=0, no done pulse, pointer=owner+1 mod NREQ, go to IDLE.
//     - Else if count==len_latched: grant=0, done[owner]=1, go to DONE.
//     - Else if ena: count+1. If ena is low: hold count, stay in RUN.
//   State DONE:
//     - done is high for exactly this one cycle; pointer=owner+1 mod NREQ; go to IDLE; count holds.
//     - count clears to 0 on the next grant.
//   Timing:
//     - With ena=1: grant is high for len+1 cycles (count 0..len), then a 1-cycle done pulse.
//     - The earliest next grant comes 2 cycles after grant falls (DONE, then IDLE).
//   len=0: grant is high for 1 cycle, then done. len=2^CW-1: count reaches all-ones with no wrap.
//   Mid-interval changes: len[owner] changes while in RUN are ignored; len is latched at grant.
//   New requests arriving in RUN/DONE wait; they are never preempted and never lost while req stays high.
//   Abort and completion in the same cycle (req low while count==len): abort wins; no done.
//   Invariants: at most one grant bit and one done bit high at a time; done never coincides with grant.
// TESTING  (NREQ=4, CW=8)
//   1. rst pulse mid-RUN (count=5) -> next sample: grant=0, count=0, busy=0, done=0, IDLE; then req[0] is served first.
//   2. req=4'b0001, len0=3, ena=1 -> grant=0001 for 4 cycles (count 0,1,2,3); done=0001 for 1 cycle; busy falls after.
//   3. req=4'b1111, all len=0, held -> grants rotate 0001,0010,0100,1000,0001; each done follows its grant by 1 cycle.
//   4. req[2] with len2=5, ena low for 3 cycles at count=2 -> count holds at 2; grant lasts 6+3=9 cycles; then done=0100.
//   5. req[1] with len1=10, req[1] dropped at count=4 -> grant=0 next cycle, no done; pending req[3] is granted 1 cycle later.
//   6. len=255 on req[0] -> count reaches 8'hFF with no wrap; grant lasts 256 cycles; then done=0001.

Source files
------------

// File: rtl/counter_scheduler.sv
// Round-robin time-sharing of one up-counter between NREQ requesters.
// Each owner counts len+1 cycles, then receives a one-cycle done pulse.
module counter_scheduler #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [CW-1:0]     count,
  output logic [NREQ-1:0]   done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   len_q, len_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   next_ptr;

  // First requester at or after the rr pointer, searching upward with wrap.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_valid && req[(int'(ptr_q) + k) % NREQ]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign next_ptr = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    count_d = count_q;
    len_d   = len_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    done_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d = S_RUN;
          grant_d = NREQ'(1) << pick_idx;
          owner_d = pick_idx;
          len_d   = len[int'(pick_idx)*CW +: CW];
          count_d = '0;
        end
      end
      S_RUN: begin
        // Abort has priority over completion when both hit in one cycle.
        if (!req[owner_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
          count_d = '0;
          ptr_d   = next_ptr;
        end else if (count_q == len_q) begin
          state_d = S_DONE;
          grant_d = '0;
          done_d  = grant_q;
        end else if (ena) begin
          count_d = count_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = next_ptr;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      count_q <= count_d;
      len_q   <= len_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign count = count_q;
  assign busy  = (state_q == S_RUN) || (state_q == S_DONE);

endmodule

// File: tb/tb_counter_scheduler.sv
// Scoreboard bench for counter_scheduler: expected done pulses and grant
// lengths are queued as stimulus is driven and checked as pulses arrive.
module tb_counter_scheduler;

  localparam int NREQ = 4;
  localparam int CW   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic [NREQ-1:0]   req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [CW-1:0]     count;
  logic [NREQ-1:0]   done;

  typedef struct {
    logic [NREQ-1:0] done_vec;
    int              glen;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   grant_run = 0;

  counter_scheduler #(.NREQ(NREQ), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .req   (req),
    .len   (len),
    .grant (grant),
    .busy  (busy),
    .count (count),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock, sampled 1 time unit after the edge; tracks grant length and invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    if (grant !== '0) grant_run++;
    checks++;
    if ($countones(grant) > 1 || $countones(done) > 1 || (grant & done) !== '0) begin
      errors++;
      $display("[TB] FAIL invariant grant=%b done=%b", grant, done);
    end
  endtask

  task automatic set_len(input int i, input logic [CW-1:0] v);
    len[i*CW +: CW] = v;
  endtask

  task automatic push_exp(input logic [NREQ-1:0] d, input int g);
    exp_t e;
    e.done_vec = d;
    e.glen     = g;
    exp_q.push_back(e);
  endtask

  // Waits for the next done pulse and scores it against the queue head.
  task automatic sb_collect(input string name, input int budget);
    exp_t e;
    int   n;
    n = 0;
    do begin
      tick();
      n++;
    end while (done === '0 && n < budget);
    checks++;
    if (done === '0) begin
      errors++;
      $display("[TB] FAIL %s timeout: done=%b after %0d cycles, required a pulse", name, done, n);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s unexpected done=%b, required none", name, done);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (done !== e.done_vec) begin
        errors++;
        $display("[TB] FAIL %s done got %b required %b", name, done, e.done_vec);
      end
      checks++;
      if (grant_run != e.glen) begin
        errors++;
        $display("[TB] FAIL %s grant length got %0d required %0d", name, grant_run, e.glen);
      end
    end
    grant_run = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ena = 1'b1;
    req = '0;
    len = '0;
    repeat (2) tick();
    checks++;
    if (grant !== 4'b0000 || count !== 8'd0 || busy !== 1'b0 || done !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_state got grant=%b count=%0d busy=%b done=%b required all 0",
               grant, count, busy, done);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL idle_no_req got busy=%b grant=%b required 0/0000", busy, grant);
    end
    grant_run = 0;
  endtask

  task automatic test_single();
    set_len(0, 8'd3);
    req = 4'b0001;
    push_exp(4'b0001, 4);
    sb_collect("single", 20);
    checks++;
    if (busy !== 1'b1 || count !== 8'd3) begin
      errors++;
      $display("[TB] FAIL single_done_cycle got busy=%b count=%0d required 1/3", busy, count);
    end
    req = '0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL single_after got busy=%b done=%b required 0/0000", busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    set_len(2, 8'd20);
    req = 4'b0100;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(count === 8'd5 && grant === 4'b0100) && n < 30);
    checks++;
    if (count !== 8'd5 || grant !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL reset_setup got grant=%b count=%0d required 0100/5", grant, count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000 || count !== 8'd0 || busy !== 1'b0 || done !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL async_reset got grant=%b count=%0d busy=%b done=%b required all 0",
               grant, count, busy, done);
    end
    len = '0;
    req = 4'b1111;
    tick();
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_held got grant=%b required 0000", grant);
    end
    rst = 1'b0;
    grant_run = 0;
    // Pointer must restart at requester 0 after reset.
    push_exp(4'b0001, 1);
    push_exp(4'b0010, 1);
    push_exp(4'b0100, 1);
    push_exp(4'b1000, 1);
    push_exp(4'b0001, 1);
    repeat (5) sb_collect("rotate", 10);
    req = '0;
    repeat (2) tick();
  endtask

  task automatic test_hold_ena();
    int n;
    set_len(2, 8'd5);
    req = 4'b0100;
    push_exp(4'b0100, 9);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(count === 8'd2 && grant === 4'b0100) && n < 10);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== 8'd2 || grant !== 4'b0100) begin
        errors++;
        $display("[TB] FAIL ena_hold%0d got count=%0d grant=%b required 2/0100", i, count, grant);
      end
    end
    ena = 1'b1;
    sb_collect("hold_ena", 20);
    req = '0;
    repeat (2) tick();
  endtask

  task automatic test_abort();
    int n;
    set_len(1, 8'd10);
    set_len(3, 8'd2);
    req = 4'b0010;
    n = 0;
    do begin
      tick();
      n++;
    end while (grant !== 4'b0010 && n < 5);
    req = 4'b1010;
    n = 0;
    while (count !== 8'd4 && n < 20) begin
      tick();
      n++;
    end
    req = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b0000 || done !== 4'b0000 || count !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort got grant=%b done=%b count=%0d busy=%b required 0000/0000/0/0",
               grant, done, count, busy);
    end
    grant_run = 0;
    push_exp(4'b1000, 3);
    tick();
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL abort_next_grant got %b required 1000", grant);
    end
    sb_collect("abort_next", 10);
    req = '0;
    repeat (2) tick();
  endtask

  task automatic test_abort_vs_done();
    int n;
    set_len(0, 8'd2);
    req = 4'b0001;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(count === 8'd2 && grant === 4'b0001) && n < 10);
    req = '0;
    tick();
    checks++;
    if (done !== 4'b0000 || grant !== 4'b0000 || count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL abort_wins got done=%b grant=%b count=%0d required 0000/0000/0",
               done, grant, count);
    end
    tick();
    checks++;
    if (done !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_wins_after got done=%b busy=%b required 0000/0", done, busy);
    end
    grant_run = 0;
  endtask

  task automatic test_len_latched();
    int n;
    set_len(2, 8'd3);
    req = 4'b0100;
    push_exp(4'b0100, 4);
    n = 0;
    do begin
      tick();
      n++;
    end while (grant !== 4'b0100 && n < 5);
    set_len(2, 8'd100);
    sb_collect("len_latched", 20);
    req = '0;
    repeat (2) tick();
  endtask

  task automatic test_max_len();
    int n;
    set_len(0, 8'hFF);
    req = 4'b0001;
    push_exp(4'b0001, 256);
    n = 0;
    do begin
      tick();
      n++;
    end while (count !== 8'hFF && n < 300);
    checks++;
    if (count !== 8'hFF || grant !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL max_reach got count=%0h grant=%b required ff/0001", count, grant);
    end
    sb_collect("max_len", 5);
    checks++;
    if (count !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL max_no_wrap got count=%0h required ff", count);
    end
    req = '0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_run();
    test_hold_ena();
    test_abort();
    test_abort_vs_done();
    test_len_latched();
    test_max_len();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover_expectations got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
